// File: rtl/pe_ctrl_responder_pkg.sv
// Shared types and default geometry for the PE control responder.
// Holds the PE command encoding and the sequencer state encoding.
package pe_ctrl_responder_pkg;

  localparam int FILT_LEN_DEF  = 5;
  localparam int IFMAP_LEN_DEF = 7;

  typedef enum logic [1:0] {
    CMD_LOAD_FILT  = 2'd0,
    CMD_LOAD_IFMAP = 2'd1,
    CMD_MAC_WIN    = 2'd2,
    CMD_SEND_PSUM  = 2'd3
  } pe_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_FILT,
    ST_LOAD_IFMAP,
    ST_COMPUTE,
    ST_SEND_PSUM,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/pe_ctrl_responder_phase_counter.sv
// Index counter for one command phase: clear, load, increment, and
// wrap to zero when incremented at the programmable limit.
module phase_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= at_limit ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/pe_ctrl_responder.sv
// Sequences one PE row pass (filter load, ifmap load, windowed MAC,
// psum send) per start token and answers with a done token.
module pe_ctrl_responder
  import pe_ctrl_responder_pkg::*;
#(
  parameter int FILT_LEN  = FILT_LEN_DEF,
  parameter int IFMAP_LEN = IFMAP_LEN_DEF,
  localparam int NUM_WIN  = IFMAP_LEN - FILT_LEN + 1,
  localparam int IDX_W    = $clog2(IFMAP_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cc_start_valid,
  input  logic             cc_start_flag,
  output logic             cc_start_ready,
  output logic             cc_done_valid,
  output logic             cc_done_flag,
  input  logic             cc_done_ready,
  output logic [1:0]       pe_cmd,
  output logic [IDX_W-1:0] pe_idx,
  output logic             pe_cmd_valid,
  input  logic             pe_cmd_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LIM_FILT  = IDX_W'(FILT_LEN - 1);
  localparam logic [IDX_W-1:0] LIM_IFMAP = IDX_W'(IFMAP_LEN - 1);
  localparam logic [IDX_W-1:0] LIM_WIN   = IDX_W'(NUM_WIN - 1);

  state_e           state_q, state_d;
  pe_cmd_e          cmd;
  logic [IDX_W-1:0] limit;
  logic [IDX_W-1:0] count;
  logic             at_limit;
  logic             flag_q;
  logic             start_xfer;
  logic             cmd_xfer;
  logic             last_xfer;

  assign start_xfer = cc_start_valid & cc_start_ready;
  assign cmd_xfer   = pe_cmd_valid & pe_cmd_ready;
  assign last_xfer  = cmd_xfer & at_limit;
  assign pe_cmd     = cmd;
  assign pe_idx     = count;

  phase_counter #(.W(IDX_W)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_xfer),
    .load     (1'b0),
    .load_val ('0),
    .inc      (cmd_xfer),
    .limit    (limit),
    .count    (count),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_xfer) flag_q <= cc_start_flag;
    end
  end

  // Command phases chain directly into each other so pe_cmd_valid never drops.
  always_comb begin
    state_d        = state_q;
    cc_start_ready = 1'b0;
    cc_done_valid  = 1'b0;
    cc_done_flag   = 1'b0;
    pe_cmd_valid   = 1'b0;
    cmd            = CMD_LOAD_FILT;
    limit          = '0;
    busy           = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy           = 1'b0;
        cc_start_ready = 1'b1;
        if (cc_start_valid) state_d = ST_LOAD_FILT;
      end
      ST_LOAD_FILT: begin
        pe_cmd_valid = 1'b1;
        cmd          = CMD_LOAD_FILT;
        limit        = LIM_FILT;
        if (last_xfer) state_d = ST_LOAD_IFMAP;
      end
      ST_LOAD_IFMAP: begin
        pe_cmd_valid = 1'b1;
        cmd          = CMD_LOAD_IFMAP;
        limit        = LIM_IFMAP;
        if (last_xfer) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        pe_cmd_valid = 1'b1;
        cmd          = CMD_MAC_WIN;
        limit        = LIM_WIN;
        if (last_xfer) state_d = ST_SEND_PSUM;
      end
      ST_SEND_PSUM: begin
        pe_cmd_valid = 1'b1;
        cmd          = CMD_SEND_PSUM;
        limit        = LIM_WIN;
        if (last_xfer) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        cc_done_valid = 1'b1;
        cc_done_flag  = flag_q;
        if (cc_done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_ctrl_responder.sv
// Self-checking bench for pe_ctrl_responder: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pe_ctrl_responder;

  localparam int FILT_LEN  = 5;
  localparam int IFMAP_LEN = 7;
  localparam int NUM_WIN   = IFMAP_LEN - FILT_LEN + 1;
  localparam int IDX_W     = $clog2(IFMAP_LEN);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cc_start_valid = 1'b0;
  logic             cc_start_flag = 1'b0;
  logic             cc_start_ready;
  logic             cc_done_valid;
  logic             cc_done_flag;
  logic             cc_done_ready = 1'b0;
  logic [1:0]       pe_cmd;
  logic [IDX_W-1:0] pe_idx;
  logic             pe_cmd_valid;
  logic             pe_cmd_ready = 1'b1;
  logic             busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;

  // model state
  bit m_idle = 1'b1;
  bit m_flag = 1'b0;
  int m_q[$];

  // event log
  int cmd_log[$];
  int xfer_cnt = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int last_done_cyc = 0;

  pe_ctrl_responder #(.FILT_LEN(FILT_LEN), .IFMAP_LEN(IFMAP_LEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cc_start_valid (cc_start_valid),
    .cc_start_flag  (cc_start_flag),
    .cc_start_ready (cc_start_ready),
    .cc_done_valid  (cc_done_valid),
    .cc_done_flag   (cc_done_flag),
    .cc_done_ready  (cc_done_ready),
    .pe_cmd         (pe_cmd),
    .pe_idx         (pe_idx),
    .pe_cmd_valid   (pe_cmd_valid),
    .pe_cmd_ready   (pe_cmd_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected command stream of one pass, encoded cmd*16 + idx.
  task automatic fill_model();
    int lens[4];
    lens[0] = FILT_LEN; lens[1] = IFMAP_LEN; lens[2] = NUM_WIN; lens[3] = NUM_WIN;
    m_q.delete();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < lens[p]; i++) m_q.push_back(p * 16 + i);
  endtask

  // Cycle counter and pe_cmd_ready driver.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (ready_mode == 1) pe_cmd_ready = 1'($urandom_range(0, 1));
    else pe_cmd_ready = 1'b1;
  end

  // Compare, event monitor and model step, all at the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_idle = 1'b1;
      m_flag = 1'b0;
      m_q.delete();
    end else begin
      if (m_idle) begin
        check("idle.start_ready", int'(cc_start_ready), 1);
        check("idle.busy", int'(busy), 0);
        check("idle.cmd_valid", int'(pe_cmd_valid), 0);
        check("idle.done_valid", int'(cc_done_valid), 0);
      end else if (m_q.size() != 0) begin
        check("cmd.start_ready", int'(cc_start_ready), 0);
        check("cmd.busy", int'(busy), 1);
        check("cmd.valid", int'(pe_cmd_valid), 1);
        check("cmd.done_valid", int'(cc_done_valid), 0);
        check("cmd.code_idx", int'(pe_cmd) * 16 + int'(pe_idx), m_q[0]);
      end else begin
        check("rpt.start_ready", int'(cc_start_ready), 0);
        check("rpt.busy", int'(busy), 1);
        check("rpt.cmd_valid", int'(pe_cmd_valid), 0);
        check("rpt.done_valid", int'(cc_done_valid), 1);
        check("rpt.done_flag", int'(cc_done_flag), int'(m_flag));
      end
      if (cc_start_valid && cc_start_ready) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (cc_done_valid && cc_done_ready) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (pe_cmd_valid && pe_cmd_ready) begin
        xfer_cnt++;
        cmd_log.push_back(int'(pe_cmd) * 16 + int'(pe_idx));
      end
      if (m_idle) begin
        if (cc_start_valid) begin
          m_idle = 1'b0;
          m_flag = cc_start_flag;
          fill_model();
        end
      end else if (m_q.size() != 0) begin
        if (pe_cmd_ready) void'(m_q.pop_front());
      end else if (cc_done_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit flag);
    int k;
    cc_start_flag  = flag;
    cc_start_valid = 1'b1;
    k = 0;
    while (!cc_start_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("start_timeout", 0, 1);
    tick();
    cc_start_valid = 1'b0;
  endtask

  task automatic wait_done_valid(input int limit);
    int k;
    k = 0;
    while (!cc_done_valid && k < limit) begin
      tick();
      k++;
    end
    if (!cc_done_valid) check("done_timeout", 0, 1);
  endtask

  initial begin
    int x0, d0, s0, k;

    // Reset state before any clock edge.
    #1;
    check("rst.start_ready", int'(cc_start_ready), 1);
    check("rst.done_valid", int'(cc_done_valid), 0);
    check("rst.done_flag", int'(cc_done_flag), 0);
    check("rst.cmd_valid", int'(pe_cmd_valid), 0);
    check("rst.cmd", int'(pe_cmd), 0);
    check("rst.idx", int'(pe_idx), 0);
    check("rst.busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Full-rate pass with flag 1.
    cc_done_ready = 1'b1;
    x0 = xfer_cnt;
    do_start(1'b1);
    wait_done_valid(60);
    check("a.done_flag", int'(cc_done_flag), 1);
    tick();
    check("a.xfers", xfer_cnt - x0, 18);
    check("a.start_to_done", last_done_cyc - last_start_cyc, 19);
    check("a.log0", cmd_log[x0 + 0], 16'h00);
    check("a.log4", cmd_log[x0 + 4], 16'h04);
    check("a.log5", cmd_log[x0 + 5], 16'h10);
    check("a.log11", cmd_log[x0 + 11], 16'h16);
    check("a.log12", cmd_log[x0 + 12], 16'h20);
    check("a.log15", cmd_log[x0 + 15], 16'h30);
    check("a.log17", cmd_log[x0 + 17], 16'h32);
    check("a.start_ready_after", int'(cc_start_ready), 1);

    // Random command backpressure.
    ready_mode = 1;
    x0 = xfer_cnt;
    do_start(1'b1);
    wait_done_valid(400);
    check("b.done_flag", int'(cc_done_flag), 1);
    tick();
    check("b.xfers", xfer_cnt - x0, 18);
    ready_mode = 0;

    // Done token held off; start pulses must be ignored.
    cc_done_ready = 1'b0;
    d0 = done_cnt;
    s0 = start_cnt;
    do_start(1'b1);
    wait_done_valid(60);
    for (int i = 0; i < 10; i++) begin
      cc_start_valid = (i == 3 || i == 6);
      cc_start_flag  = 1'b0;
      tick();
    end
    cc_start_valid = 1'b0;
    check("c.done_valid_held", int'(cc_done_valid), 1);
    check("c.done_flag_held", int'(cc_done_flag), 1);
    check("c.starts", start_cnt - s0, 1);
    cc_done_ready = 1'b1;
    tick();
    check("c.dones", done_cnt - d0, 1);
    check("c.start_ready_next", int'(cc_start_ready), 1);
    check("c.busy_next", int'(busy), 0);

    // Reset in the middle of the ifmap load.
    d0 = done_cnt;
    do_start(1'b1);
    k = 0;
    while (!(pe_cmd_valid && pe_cmd == 2'd1 && pe_idx == IDX_W'(3)) && k < 40) begin
      tick();
      k++;
    end
    check("d.reached_ifmap3", int'(pe_cmd_valid && pe_cmd == 2'd1 && pe_idx == IDX_W'(3)), 1);
    #2 rst_n = 1'b0;
    #1;
    check("d.rst.start_ready", int'(cc_start_ready), 1);
    check("d.rst.done_valid", int'(cc_done_valid), 0);
    check("d.rst.done_flag", int'(cc_done_flag), 0);
    check("d.rst.cmd_valid", int'(pe_cmd_valid), 0);
    check("d.rst.cmd", int'(pe_cmd), 0);
    check("d.rst.idx", int'(pe_idx), 0);
    check("d.rst.busy", int'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    check("d.no_done", done_cnt - d0, 0);
    x0 = xfer_cnt;
    do_start(1'b0);
    wait_done_valid(60);
    check("d.done_flag0", int'(cc_done_flag), 0);
    tick();
    check("d.xfers", xfer_cnt - x0, 18);
    check("d.dones", done_cnt - d0, 1);

    // Back-to-back starts with start_valid held.
    s0 = start_cnt;
    cc_start_flag  = 1'b1;
    cc_start_valid = 1'b1;
    k = 0;
    while (start_cnt < s0 + 2 && k < 100) begin
      tick();
      k++;
    end
    cc_start_valid = 1'b0;
    check("e.two_starts", start_cnt - s0, 2);
    check("e.restart_gap", last_start_cyc - last_done_cyc, 1);
    wait_done_valid(60);
    tick();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
